// File: rtl/axis_demux.sv
// Unpacks two-beat 128-bit AXI-Stream frames into eight 32-bit channel words.
// Each word is presented with its own valid flag until that channel's consumer acknowledges it.
module axis_demux #(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [127:0]         M_AXIS_tdata,
    input  logic                 M_AXIS_tvalid,
    input  logic                 M_AXIS_tlast,
    output logic                 M_AXIS_tready,
    output logic [31:0]          data1,
    output logic [31:0]          data2,
    output logic [31:0]          data3,
    output logic [31:0]          data4,
    output logic [31:0]          data5,
    output logic [31:0]          data6,
    output logic [31:0]          data7,
    output logic [31:0]          data8,
    output logic                 flag1_out,
    output logic                 flag2_out,
    output logic                 flag3_out,
    output logic                 flag4_out,
    output logic                 flag5_out,
    output logic                 flag6_out,
    output logic                 flag7_out,
    output logic                 flag8_out,
    input  logic                 flag1_in,
    input  logic                 flag2_in,
    input  logic                 flag3_in,
    input  logic                 flag4_in,
    input  logic                 flag5_in,
    input  logic                 flag6_in,
    input  logic                 flag7_in,
    input  logic                 flag8_in,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned CH_W   = 32;
    localparam int unsigned N_CH   = 8;
    localparam int unsigned HALF_N = N_CH / 2;
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BEAT1,
        ST_BEAT2,
        ST_RESYNC,
        ST_PRESENT
    } state_e;

    state_e                         state_q, state_d;
    logic [N_CH-1:0][CH_W-1:0]      data_q, data_d;
    logic [N_CH-1:0]                flags_q, flags_d;
    logic                           tready_q, tready_d;
    logic                           frame_err_q, frame_err_d;
    logic [ERR_CNT_W-1:0]           err_cnt_q, err_cnt_d;
    logic [N_CH-1:0]                acks_c;
    logic                           accept_c;
    logic                           err_hit_c;

    assign acks_c   = {flag8_in, flag7_in, flag6_in, flag5_in,
                       flag4_in, flag3_in, flag2_in, flag1_in};
    assign accept_c = M_AXIS_tvalid & tready_q;

    // Frame parser: next state, channel data, flags and error accounting
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        flags_d   = flags_q;
        err_hit_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_BEAT1;
                end
            end
            ST_BEAT1: begin
                if (accept_c) begin
                    if (M_AXIS_tlast) begin
                        err_hit_c = 1'b1;
                    end else begin
                        data_d[HALF_N-1:0] = M_AXIS_tdata;
                        state_d            = ST_BEAT2;
                    end
                end
            end
            ST_BEAT2: begin
                if (accept_c) begin
                    if (M_AXIS_tlast) begin
                        data_d[N_CH-1:HALF_N] = M_AXIS_tdata;
                        flags_d               = '1;
                        state_d               = ST_PRESENT;
                    end else begin
                        err_hit_c = 1'b1;
                        state_d   = ST_RESYNC;
                    end
                end
            end
            ST_RESYNC: begin
                if (accept_c && M_AXIS_tlast) begin
                    state_d = ST_BEAT1;
                end
            end
            ST_PRESENT: begin
                flags_d = flags_q & ~acks_c;
                if (flags_d == '0) begin
                    state_d = start ? ST_BEAT1 : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                flags_d = '0;
            end
        endcase

        frame_err_d = err_hit_c;
        err_cnt_d   = err_cnt_q;
        if (err_hit_c && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end

        // Ready is registered from the upcoming state so it tracks the state register exactly
        tready_d = (state_d == ST_BEAT1) || (state_d == ST_BEAT2) || (state_d == ST_RESYNC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            flags_q     <= '0;
            tready_q    <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            flags_q     <= flags_d;
            tready_q    <= tready_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign M_AXIS_tready = tready_q;
    assign frame_err     = frame_err_q;
    assign err_count     = err_cnt_q;

    assign data1 = data_q[0];
    assign data2 = data_q[1];
    assign data3 = data_q[2];
    assign data4 = data_q[3];
    assign data5 = data_q[4];
    assign data6 = data_q[5];
    assign data7 = data_q[6];
    assign data8 = data_q[7];

    assign flag1_out = flags_q[0];
    assign flag2_out = flags_q[1];
    assign flag3_out = flags_q[2];
    assign flag4_out = flags_q[3];
    assign flag5_out = flags_q[4];
    assign flag6_out = flags_q[5];
    assign flag7_out = flags_q[6];
    assign flag8_out = flags_q[7];

endmodule
